// File: rtl/constraint_sweep_ctrl_if.sv
// Bus bundle between constraint_sweep_ctrl and its two neighbours: the
// position RAM (read/write ports) and the combinational constraint unit.
//   master : controller side (drives strobes, addresses, write data, ec operands)
//   slave  : RAM / constraint-unit side (drives read data and enforced result)
interface constraint_sweep_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_x;
  logic [DATA_W-1:0] rd_y;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_x;
  logic [DATA_W-1:0] wr_y;
  logic [DATA_W-1:0] ec_up_x;
  logic [DATA_W-1:0] ec_up_y;
  logic [DATA_W-1:0] ec_x;
  logic [DATA_W-1:0] ec_y;
  logic [DATA_W-1:0] ec_down_x;
  logic [DATA_W-1:0] ec_down_y;
  logic [DATA_W-1:0] ec_x_enf;
  logic [DATA_W-1:0] ec_y_enf;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_x, wr_y,
    output ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y,
    input  rd_x, rd_y, ec_x_enf, ec_y_enf
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_x, wr_y,
    input  ec_up_x, ec_up_y, ec_x, ec_y, ec_down_x, ec_down_y,
    output rd_x, rd_y, ec_x_enf, ec_y_enf
  );
endinterface

// File: rtl/constraint_sweep_ctrl.sv
// Gauss-Seidel sweep controller for a chain of Q16.16 particle positions.
// Walks interior points 1..N_POINTS-2, presenting (up, current, down) to the
// constraint unit and writing the enforced value back; the enforced value is
// forwarded as the next point's "up" neighbour.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : begin request, accepted only in IDLE
//   busy       : high while a sweep sequence is in progress
//   done       : one-cycle pulse after the final write of the final sweep
//   bus        : RAM read/write ports and constraint-unit operands/result
module constraint_sweep_ctrl #(
  parameter int N_POINTS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int SWEEPS   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  constraint_sweep_ctrl_if.master bus
);

  localparam int                SW_W       = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;
  localparam logic [SW_W-1:0]   SWEEP_LAST = SW_W'(SWEEPS - 1);
  localparam logic [ADDR_W-1:0] I_LAST     = ADDR_W'(N_POINTS - 2);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CALC, S_SHIFT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        fill_q, fill_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [SW_W-1:0]   sweep_q, sweep_d;
  logic [DATA_W-1:0] w0x_q, w0x_d, w0y_q, w0y_d;
  logic [DATA_W-1:0] w1x_q, w1x_d, w1y_q, w1y_d;
  logic [DATA_W-1:0] w2x_q, w2x_d, w2y_q, w2y_d;
  logic [DATA_W-1:0] enfx_q, enfx_d, enfy_q, enfy_d;

  assign bus.ec_up_x   = w0x_q;
  assign bus.ec_up_y   = w0y_q;
  assign bus.ec_x      = w1x_q;
  assign bus.ec_y      = w1y_q;
  assign bus.ec_down_x = w2x_q;
  assign bus.ec_down_y = w2y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      i_q     <= '0;
      sweep_q <= '0;
      w0x_q   <= '0;
      w0y_q   <= '0;
      w1x_q   <= '0;
      w1y_q   <= '0;
      w2x_q   <= '0;
      w2y_q   <= '0;
      enfx_q  <= '0;
      enfy_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      i_q     <= i_d;
      sweep_q <= sweep_d;
      w0x_q   <= w0x_d;
      w0y_q   <= w0y_d;
      w1x_q   <= w1x_d;
      w1y_q   <= w1y_d;
      w2x_q   <= w2x_d;
      w2y_q   <= w2y_d;
      enfx_q  <= enfx_d;
      enfy_q  <= enfy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    i_d         = i_q;
    sweep_d     = sweep_q;
    w0x_d       = w0x_q;
    w0y_d       = w0y_q;
    w1x_d       = w1x_q;
    w1y_d       = w1y_q;
    w2x_d       = w2x_q;
    w2y_d       = w2y_q;
    enfx_d      = enfx_q;
    enfy_d      = enfy_q;
    busy        = 1'b0;
    done        = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_x    = '0;
    bus.wr_y    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          fill_d  = '0;
          i_d     = ADDR_W'(1);
          sweep_d = '0;
        end
      end

      // Reads of points 0..2 issued in fill cycles 0..2; each returns one
      // cycle later and lands in W0, W1, W2 respectively.
      S_FILL: begin
        busy   = 1'b1;
        fill_d = fill_q + 2'd1;
        if (fill_q != 2'd3) begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = ADDR_W'(fill_q);
        end
        case (fill_q)
          2'd1: begin
            w0x_d = bus.rd_x;
            w0y_d = bus.rd_y;
          end
          2'd2: begin
            w1x_d = bus.rd_x;
            w1y_d = bus.rd_y;
          end
          2'd3: begin
            w2x_d   = bus.rd_x;
            w2y_d   = bus.rd_y;
            state_d = S_CALC;
          end
          default: ;
        endcase
      end

      // Enforced result is written and also held in enf_q so the next point
      // sees the updated value as its "up" neighbour.
      S_CALC: begin
        busy        = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = i_q;
        bus.wr_x    = bus.ec_x_enf;
        bus.wr_y    = bus.ec_y_enf;
        enfx_d      = bus.ec_x_enf;
        enfy_d      = bus.ec_y_enf;
        if (int'(i_q) + 2 <= N_POINTS - 1) begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = i_q + ADDR_W'(2);
        end
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        busy  = 1'b1;
        w0x_d = enfx_q;
        w0y_d = enfy_q;
        w1x_d = w2x_q;
        w1y_d = w2y_q;
        w2x_d = bus.rd_x;
        w2y_d = bus.rd_y;
        if (i_q == I_LAST) begin
          if (sweep_q != SWEEP_LAST) begin
            sweep_d = sweep_q + SW_W'(1);
            fill_d  = '0;
            i_d     = ADDR_W'(1);
            state_d = S_FILL;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          i_d     = i_q + ADDR_W'(1);
          state_d = S_CALC;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_constraint_sweep_ctrl.sv
module tb_constraint_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst16_n;
  logic start3, start16, start2;
  logic busy3, done3, busy16, done16, busy2, done2;

  constraint_sweep_ctrl_if #(.ADDR_W(2), .DATA_W(32)) b3 ();
  constraint_sweep_ctrl_if #(.ADDR_W(4), .DATA_W(32)) b16 ();
  constraint_sweep_ctrl_if #(.ADDR_W(4), .DATA_W(32)) b2 ();

  constraint_sweep_ctrl #(.N_POINTS(3), .ADDR_W(2), .DATA_W(32), .SWEEPS(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3), .bus(b3));
  constraint_sweep_ctrl #(.N_POINTS(16), .ADDR_W(4), .DATA_W(32), .SWEEPS(1)) u16 (
    .clk(clk), .rst_n(rst16_n), .start(start16), .busy(busy16), .done(done16), .bus(b16));
  constraint_sweep_ctrl #(.N_POINTS(16), .ADDR_W(4), .DATA_W(32), .SWEEPS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .bus(b2));

  // Constraint-unit stubs.
  // u3  : identity.
  // u16 : x forwards from up (+1.0), y copies down.
  // u2  : x accumulates on itself (+1.0 per sweep, shows the RAM re-read),
  //       y forwards from up (+1.0).
  assign b3.ec_x_enf  = b3.ec_x;
  assign b3.ec_y_enf  = b3.ec_y;
  assign b16.ec_x_enf = b16.ec_up_x + 32'h0001_0000;
  assign b16.ec_y_enf = b16.ec_down_y;
  assign b2.ec_x_enf  = b2.ec_x + 32'h0001_0000;
  assign b2.ec_y_enf  = b2.ec_up_y + 32'h0001_0000;

  // Position RAMs: registered read, write on clock edge.
  logic [31:0] m3x [4];
  logic [31:0] m3y [4];
  logic [31:0] m16x[16];
  logic [31:0] m16y[16];
  logic [31:0] m2x [16];
  logic [31:0] m2y [16];
  int unsigned wr3_cnt = 0;
  int unsigned rd0_cnt2 = 0;
  logic [3:0]  wlog16[$];

  always @(posedge clk) begin
    if (b3.rd_en) begin
      b3.rd_x <= m3x[b3.rd_addr];
      b3.rd_y <= m3y[b3.rd_addr];
    end
    if (b3.wr_en) begin
      m3x[b3.wr_addr] <= b3.wr_x;
      m3y[b3.wr_addr] <= b3.wr_y;
      wr3_cnt <= wr3_cnt + 1;
    end
    if (b16.rd_en) begin
      b16.rd_x <= m16x[b16.rd_addr];
      b16.rd_y <= m16y[b16.rd_addr];
    end
    if (b16.wr_en) begin
      m16x[b16.wr_addr] <= b16.wr_x;
      m16y[b16.wr_addr] <= b16.wr_y;
      wlog16.push_back(b16.wr_addr);
    end
    if (b2.rd_en) begin
      b2.rd_x <= m2x[b2.rd_addr];
      b2.rd_y <= m2y[b2.rd_addr];
      if (b2.rd_addr == 4'd0) rd0_cnt2 <= rd0_cnt2 + 1;
    end
    if (b2.wr_en) begin
      m2x[b2.wr_addr] <= b2.wr_x;
      m2y[b2.wr_addr] <= b2.wr_y;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_x;
    logic [31:0] wr_y;
    logic [31:0] up_x;
  } vec_t;

  vec_t vt[9];

  function automatic logic [159:0] pack3();
    return {b3.ec_up_x, b3.wr_y, b3.wr_x, b3.wr_addr, b3.wr_en,
            b3.rd_addr, b3.rd_en, done3, busy3};
  endfunction

  function automatic logic [159:0] packv(input vec_t v);
    return {v.up_x, v.wr_y, v.wr_x, v.wr_addr, v.wr_en, v.rd_addr, v.rd_en, v.done, v.busy};
  endfunction

  initial begin
    logic        seen;
    int          bc, dc, bad;
    logic [31:0] ex;

    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0000a51f};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0000a51f};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 32'h00003785, 32'h0003c4a4, 32'h0000a51f};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0000a51f};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h00003785};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h00003785};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h00003785};

    rst_n = 1'b0; rst16_n = 1'b0;
    start3 = 1'b0; start16 = 1'b0; start2 = 1'b0;
    m3x[0] <= 32'h0000a51f; m3y[0] <= 32'h0001e800;
    m3x[1] <= 32'h00003785; m3y[1] <= 32'h0003c4a4;
    m3x[2] <= 32'h00000614; m3y[2] <= 32'h0005aae1;
    m3x[3] <= 32'h0;        m3y[3] <= 32'h0;
    for (int a = 0; a < 16; a++) begin
      m16x[a] <= 32'h0; m16y[a] <= 32'h0;
      m2x[a]  <= 32'h0; m2y[a]  <= 32'h0;
    end
    tick(); tick();
    check("reset u3 outputs", pack3(), 160'h0);
    check("reset u16 outputs",
          {b16.rd_en, b16.rd_addr, b16.wr_en, b16.wr_addr, b16.wr_x, b16.ec_x, busy16, done16}, 160'h0);
    @(negedge clk);
    rst_n = 1'b1; rst16_n = 1'b1;
    tick();

    // N_POINTS=3 single triple, cycle by cycle
    for (int r = 0; r < 9; r++) begin
      start3 = vt[r].start;
      tick();
      check($sformatf("u3 row %0d", r), pack3(), packv(vt[r]));
    end
    start3 = 1'b0;
    check("u3 write count", 160'(wr3_cnt), 160'd1);
    check("u3 ram0 untouched", {m3x[0], m3y[0]}, {32'h0000a51f, 32'h0001e800});
    check("u3 ram1 value", {m3x[1], m3y[1]}, {32'h00003785, 32'h0003c4a4});
    check("u3 ram2 untouched", {m3x[2], m3y[2]}, {32'h00000614, 32'h0005aae1});

    // N_POINTS=16 Gauss-Seidel forwarding
    wlog16.delete();
    start16 = 1'b1; tick(); start16 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (done16) seen = 1'b1; else tick();
    end
    check("u16 done reached", 160'(seen), 160'd1);
    tick();
    check("u16 write count", 160'(wlog16.size()), 160'd14);
    bad = 0;
    for (int k = 0; k < wlog16.size(); k++)
      if (wlog16[k] != 4'(k + 1)) bad++;
    check("u16 write order", 160'(bad), 160'd0);
    bad = 0;
    for (int a = 1; a <= 14; a++) begin
      ex = 32'(a) << 16;
      if (m16x[a] !== ex) bad++;
    end
    check("u16 forwarded x", 160'(bad), 160'd0);
    check("u16 endpoints x", {m16x[0], m16x[15]}, 160'h0);
    bad = 0;
    for (int a = 0; a < 16; a++) if (m16y[a] !== 32'h0) bad++;
    check("u16 y all zero", 160'(bad), 160'd0);

    // start held high across a whole sweep: one sweep only
    start16 = 1'b1;
    bc = 0; dc = 0;
    for (int k = 0; k < 33; k++) begin
      tick();
      if (busy16) bc++;
      if (done16) dc++;
    end
    start16 = 1'b0;
    check("held start busy cycles", 160'(bc), 160'd32);
    check("held start done pulses", 160'(dc), 160'd1);
    bc = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (busy16) bc++;
    end
    check("held start no restart", 160'(bc), 160'd0);

    // SWEEPS=2 latency, single-cycle done, re-read of point 0
    start2 = 1'b1; tick(); start2 = 1'b0;
    seen = 1'b0; bc = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (busy2) bc++;
      if (done2) seen = 1'b1; else tick();
    end
    check("u2 done reached", 160'(seen), 160'd1);
    check("u2 busy cycles", 160'(bc), 160'd64);
    tick();
    check("u2 done width", {done2, busy2}, 160'd0);
    check("u2 point0 reads", 160'(rd0_cnt2), 160'd2);
    bad = 0;
    for (int a = 1; a <= 14; a++) begin
      ex = 32'(a) << 16;
      if (m2x[a] !== 32'h0002_0000 || m2y[a] !== ex) bad++;
    end
    check("u2 two-sweep values", 160'(bad), 160'd0);
    check("u2 endpoints", {m2x[0], m2y[0], m2x[15], m2y[15]}, 160'h0);

    // reset during the 5th CALC
    for (int a = 0; a < 16; a++) begin
      m16x[a] <= 32'h1000 + 32'(a);
      m16y[a] <= 32'h2000 + 32'(a);
    end
    tick();
    start16 = 1'b1; tick(); start16 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (b16.wr_en && b16.wr_addr == 4'd5) seen = 1'b1; else tick();
    end
    check("5th CALC reached", 160'(seen), 160'd1);
    rst16_n = 1'b0;
    #1;
    check("abort outputs zero",
          {b16.wr_en, b16.wr_addr, b16.wr_x, b16.wr_y, b16.rd_en, b16.rd_addr,
           b16.ec_up_x, b16.ec_x, b16.ec_down_y, busy16, done16}, 160'h0);
    tick();
    @(negedge clk);
    rst16_n = 1'b1;
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done16) dc++;
    end
    check("abort no done", 160'(dc), 160'd0);
    bad = 0;
    for (int a = 5; a < 16; a++)
      if (m16x[a] !== 32'h1000 + 32'(a) || m16y[a] !== 32'h2000 + 32'(a)) bad++;
    check("abort ram 5..15 intact", 160'(bad), 160'd0);

    start16 = 1'b1; tick(); start16 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (done16) seen = 1'b1; else tick();
    end
    check("post-abort done", 160'(seen), 160'd1);
    tick();
    bad = 0;
    for (int a = 1; a <= 14; a++)
      if (m16x[a] !== 32'h1000 + (32'(a) << 16)) bad++;
    check("post-abort sweep x", 160'(bad), 160'd0);
    check("post-abort endpoints", {m16x[0], m16x[15]}, {32'h1000, 32'h100f});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
